// File: rtl/vga_timing_rx.sv
// VGA sync sink: recovers pixel coordinates, the active window and lock status from h_sync/v_sync.
// Optional macro VGA_RX_MEASURE_EN adds h_total/v_total line and frame length measurement.
module vga_timing_rx #(
    parameter int unsigned H_COUNT_MAX = 800,
    parameter int unsigned V_COUNT_MAX = 525,
    parameter int unsigned H_ACT_START = 144,
    parameter int unsigned H_ACT_END   = 784,
    parameter int unsigned V_ACT_START = 35,
    parameter int unsigned V_ACT_END   = 515,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           pix_en,
    input  logic                           h_sync,
    input  logic                           v_sync,
    output logic [$clog2(H_COUNT_MAX)-1:0] rx_x,
    output logic [$clog2(V_COUNT_MAX)-1:0] rx_y,
    output logic                           rx_active,
    output logic                           frame_start,
    output logic                           locked,
    output logic [7:0]                     err_count,
    output logic [$clog2(H_COUNT_MAX):0]   h_total,
    output logic [$clog2(V_COUNT_MAX):0]   v_total
);
    localparam int unsigned H_BITS = $clog2(H_COUNT_MAX);
    localparam int unsigned V_BITS = $clog2(V_COUNT_MAX);
    localparam int unsigned G_BITS = $clog2(LOCK_FRAMES + 1);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    state_t              state_q, state_d;
    logic                hs_q, hs_d, vs_line_q, vs_line_d;
    logic                frame_bad_q, frame_bad_d;
    logic [H_BITS-1:0]   h_cnt_q, h_cnt_d, rx_x_q, rx_x_d;
    logic [V_BITS-1:0]   v_cnt_q, v_cnt_d, rx_y_q, rx_y_d;
    logic [G_BITS-1:0]   good_q, good_d;
    logic                rx_active_q, rx_active_d;
    logic                frame_start_q, frame_start_d;
    logic                locked_q, locked_d;
    logic [7:0]          err_cnt_q, err_cnt_d;
    logic                h_edge, v_edge, line_err, timeout, frame_err, err_evt, count_err;

    always_comb begin
        // edge detection and line/frame judgement
        h_edge    = pix_en && hs_q && !h_sync;
        v_edge    = h_edge && vs_line_q && !v_sync;
        line_err  = h_edge && (h_cnt_q != H_BITS'(H_COUNT_MAX - 1));
        timeout   = pix_en && !h_edge && (h_cnt_q == H_BITS'(H_COUNT_MAX - 1));
        frame_err = v_edge && ((v_cnt_q != V_BITS'(V_COUNT_MAX - 1)) || line_err || frame_bad_q);
        err_evt   = line_err || timeout || frame_err;

        hs_d        = hs_q;
        vs_line_d   = vs_line_q;
        h_cnt_d     = h_cnt_q;
        v_cnt_d     = v_cnt_q;
        frame_bad_d = frame_bad_q;
        if (pix_en) begin
            hs_d        = h_sync;
            h_cnt_d     = h_edge ? '0 : ((&h_cnt_q) ? h_cnt_q : h_cnt_q + H_BITS'(1));
            frame_bad_d = v_edge ? 1'b0 : (frame_bad_q || line_err || timeout);
        end
        if (h_edge) begin
            vs_line_d = v_sync;
            v_cnt_d   = v_edge ? '0 : ((&v_cnt_q) ? v_cnt_q : v_cnt_q + V_BITS'(1));
        end

        state_d   = state_q;
        good_d    = good_q;
        count_err = 1'b0;
        case (state_q)
            SEARCH: begin
                // the partial frame before the first v-edge is never judged
                if (v_edge) begin
                    state_d = TRACK;
                    good_d  = '0;
                end
            end
            TRACK: begin
                if (err_evt) begin
                    state_d   = SEARCH;
                    count_err = 1'b1;
                end else if (v_edge) begin
                    good_d = good_q + G_BITS'(1);
                    if (good_d == G_BITS'(LOCK_FRAMES)) state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (err_evt) begin
                    state_d   = SEARCH;
                    count_err = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase

        err_cnt_d = (count_err && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
        locked_d  = (state_d == LOCKED);

        // window follows the freshly updated counters so it lines up with the sampled pixel
        rx_active_d   = rx_active_q;
        rx_x_d        = rx_x_q;
        rx_y_d        = rx_y_q;
        frame_start_d = 1'b0;
        if (pix_en) begin
            rx_active_d   = locked_d
                         && (h_cnt_d >= H_BITS'(H_ACT_START)) && (h_cnt_d < H_BITS'(H_ACT_END))
                         && (v_cnt_d >= V_BITS'(V_ACT_START)) && (v_cnt_d < V_BITS'(V_ACT_END));
            rx_x_d        = rx_active_d ? h_cnt_d - H_BITS'(H_ACT_START) : '0;
            rx_y_d        = rx_active_d ? v_cnt_d - V_BITS'(V_ACT_START) : '0;
            frame_start_d = v_edge && locked_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= SEARCH;
            hs_q          <= 1'b1;
            vs_line_q     <= 1'b1;
            frame_bad_q   <= 1'b0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            good_q        <= '0;
            rx_x_q        <= '0;
            rx_y_q        <= '0;
            rx_active_q   <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            hs_q          <= hs_d;
            vs_line_q     <= vs_line_d;
            frame_bad_q   <= frame_bad_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            good_q        <= good_d;
            rx_x_q        <= rx_x_d;
            rx_y_q        <= rx_y_d;
            rx_active_q   <= rx_active_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign rx_x        = rx_x_q;
    assign rx_y        = rx_y_q;
    assign rx_active   = rx_active_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign err_count   = err_cnt_q;

`ifdef VGA_RX_MEASURE_EN
    logic [H_BITS:0] h_total_q, h_total_d;
    logic [V_BITS:0] v_total_q, v_total_d;

    // lengths are captured in every lock state; the extra bit keeps the +1 from wrapping
    always_comb begin
        h_total_d = h_total_q;
        v_total_d = v_total_q;
        if (h_edge) h_total_d = {1'b0, h_cnt_q} + (H_BITS + 1)'(1);
        if (v_edge) v_total_d = {1'b0, v_cnt_q} + (V_BITS + 1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_total_q <= '0;
            v_total_q <= '0;
        end else begin
            h_total_q <= h_total_d;
            v_total_q <= v_total_d;
        end
    end

    assign h_total = h_total_q;
    assign v_total = v_total_q;
`else
    assign h_total = '0;
    assign v_total = '0;
`endif

endmodule

// File: doc/vga_timing_rx.md
# vga_timing_rx

Pixel-domain VGA timing receiver: the sink end of the VGA sync interface. Samples active-low `h_sync`/`v_sync` at the pixel enable rate, reconstructs pixel coordinates and the active-video window, and runs a lock state machine that verifies line and frame totals against the configured 640x480@60 timing. Sits behind a sync source (timing generator, capture front-end, or loopback) and feeds downstream capture, checkers or framebuffer write logic.

## Interface
- `H_COUNT_MAX`, 800: pixels per line, including sync and porches.
- `V_COUNT_MAX`, 525: lines per frame.
- `H_ACT_START`, 144: first active pixel, counted from the `h_sync` falling edge.
- `H_ACT_END`, 784: first inactive pixel after the active region.
- `V_ACT_START`, 35: first active line, counted from the `v_sync` falling edge.
- `V_ACT_END`, 515: first inactive line after the active region.
- `LOCK_FRAMES`, 2: consecutive good frames needed to assert `locked`.
- `H_BITS` = `$clog2(H_COUNT_MAX)`, `V_BITS` = `$clog2(V_COUNT_MAX)`.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `pix_en` in 1: pixel-rate enable, one `clk` wide; all sampling happens only when it is high.
- `h_sync` in 1: horizontal sync, active low, synchronous to `clk`.
- `v_sync` in 1: vertical sync, active low, synchronous to `clk`.
- `rx_x` out `H_BITS`: active-region x; 0 outside the active region.
- `rx_y` out `V_BITS`: active-region y; 0 outside the active region.
- `rx_active` out 1: current pixel is inside the active window.
- `frame_start` out 1: one-`clk` pulse at pixel (0,0) of each frame.
- `locked` out 1: timing verified.
- `err_count` out 8: saturating count of timing errors.
- `h_total` out `H_BITS+1`: last measured line length.
- `v_total` out `V_BITS+1`: last measured frame length.

## Operation
- **Sync sampling.** On `pix_en`, register `hs_q <= h_sync`. An h-edge is `hs_q==1 && h_sync==0`. At reset `hs_q = 1` and `vs_line_q = 1`.
- **Horizontal counter.**
  - On an h-edge, `h_cnt <= 0`.
  - Otherwise `h_cnt` increments and saturates at all-ones (no wrap).
- **Vertical counter.** Updated only on an h-edge.
  - A v-edge is `vs_line_q==1 && v_sync==0`, with `vs_line_q <= v_sync` registered once per line.
  - On a v-edge, `v_cnt <= 0`; otherwise `v_cnt` increments and saturates.
- **Active window.** `rx_active = locked && H_ACT_START<=h_cnt<H_ACT_END && V_ACT_START<=v_cnt<V_ACT_END`.
  - `rx_x = h_cnt-H_ACT_START` and `rx_y = v_cnt-V_ACT_START` while active, else 0.
- **Line check.** On an h-edge, the line is good iff the old `h_cnt == H_COUNT_MAX-1`.
  - `h_cnt` reaching `H_COUNT_MAX` without an h-edge is a timeout error.
- **Frame check.** On a v-edge, the frame is good iff the old `v_cnt == V_COUNT_MAX-1` and no line error occurred in that frame.
- **FSM states:** `SEARCH`, `TRACK`, `LOCKED`.
  - `SEARCH`: the first v-edge moves to `TRACK` and sets `good_frames` to 0. The first partial frame is never judged.
  - `TRACK`: each good frame increments `good_frames`. Reaching `LOCK_FRAMES` moves to `LOCKED`. Any line, frame or timeout error moves to `SEARCH`.
  - `LOCKED`: any error moves to `SEARCH`, deasserts `locked` and increments `err_count`.
- **`err_count`.** Increments on every error detected in `TRACK` or `LOCKED`. Saturates at 255 and clears only on `rst`.
- **Simultaneous error sources.** A line error and a frame error on the same h-edge count as one error.
- **`frame_start`.** Pulses for one `clk` on the edge where the v-edge is processed, only while `locked`.

## Timing
- All outputs are registered and update on the `clk` edge where `pix_en=1`. They hold between enables.
- Latency: the `h_sync` falling edge sampled at edge N gives `h_cnt=0`, visible after edge N.
- `rx_active` tracks `h_cnt` with zero additional latency, so it is aligned to the sampled pixel.
- Reset values:
  - `h_cnt=0`, `v_cnt=0`, state `SEARCH`.
  - `rx_x=0`, `rx_y=0`, `rx_active=0`, `frame_start=0`.
  - `locked=0`, `err_count=0`, `h_total=0`, `v_total=0`.
- Reset mid-frame: all state clears on the next `clk` edge and lock restarts from `SEARCH`. No output glitch beyond returning to reset values.
- With `pix_en` held low, nothing changes, including the timeout.

## Configuration
- `VGA_RX_MEASURE_EN` defined:
  - `h_total` latches the old `h_cnt+1` on every h-edge.
  - `v_total` latches the old `v_cnt+1` on every v-edge.
  - Both saturate and update in every FSM state.
- `VGA_RX_MEASURE_EN` undefined: `h_total` and `v_total` are tied to 0 and their registers are removed. Lock and error behaviour are unchanged.

## Test plan
- **Nominal lock.** Drive 800x525 syncs (h low 96, v low 2 lines) with `pix_en` every 2 `clk`s. Expect `locked=1` at the start of the third v-edge. Expect `frame_start` pulses every 840000 `clk`. Pixel h=144,v=35 gives `rx_x=0,rx_y=0,rx_active=1`. Pixel h=783,v=514 gives `rx_x=639,rx_y=479`.
- **Short line.** While locked, inject one 799-pixel line. Expect `locked` to drop at that h-edge, `err_count=1`, and relock 2 good frames later.
- **Missing h_sync.** Hold `h_sync=1` while locked. Expect a timeout error at `h_cnt=800`, `h_cnt` saturating, and `err_count` incrementing once.
- **Long frame.** Drive a 526-line frame. Expect an error on the next v-edge and a return to `SEARCH`. With `VGA_RX_MEASURE_EN` defined, expect `v_total=526`.
- **Reset mid-frame.** Pulse `rst` for one `clk` at line 200 while locked. Expect all outputs at reset values the next cycle and `locked` re-asserted after 2 full frames.
- **Saturation.** Force 300 errors. Expect `err_count=255` to hold with no wrap.
